// File: rtl/ps2_host_tx_pkg.sv
// Shared PS/2 host-transmit definitions: FSM encoding, frame constants and
// the on-wire frame builder.
package ps2_host_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_REQ,
    ST_RELEASE,
    ST_ACK,
    ST_WAIT_IDLE
  } state_t;

  // data + parity + stop; the receive path sizes its shifter from this too
  localparam int   PS2_FRAME_BITS = 10;
  localparam logic PS2_ACK_OK     = 1'b0;

  // {stop, odd parity, data}, shifted out LSB first after the start bit
  function automatic logic [PS2_FRAME_BITS-1:0] ps2_frame(input logic [7:0] d);
    return {1'b1, ~^d, d};
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizer for one PS/2 pad plus a registered falling-edge
// detector. Flops reset high to match an idle open-drain line.
module ps2_line_sync (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_line,
  output logic o_sync,
  output logic o_fall
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
      r_prev <= 1'b1;
    end else begin
      r_meta <= i_line;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_sync = r_sync;
  assign o_fall = r_prev & ~r_sync;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, issues the request to
// send, clocks out one command byte on device clocks and checks the ack.
module ps2_host_tx
  import ps2_host_tx_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_tx_valid,
  input  logic [7:0] i_tx_data,
  output logic       o_tx_ready,
  input  logic       i_ps2_clk,
  input  logic       i_ps2_data,
  output logic       o_ps2_clk_oe,
  output logic       o_ps2_data_oe,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_ack_error,
  output logic       o_timeout
);

  localparam int ICW = $clog2(INHIBIT_CYCLES + 1);
  localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);

  state_t                    r_state;
  logic [ICW-1:0]            r_cnt;
  logic [TCW-1:0]            r_tcnt;
  logic [PS2_FRAME_BITS-1:0] r_shreg;
  logic [3:0]                r_bitcnt;
  logic                      r_nack;
  logic                      r_clk_oe;
  logic                      r_data_oe;
  logic                      r_done;
  logic                      r_ack_error;
  logic                      r_timeout;

  logic w_clk_sync;
  logic w_clk_fall;
  logic w_data_sync;
  logic w_data_fall_unused;
  logic w_tmo_run;
  logic w_tmo_hit;

  ps2_line_sync u_clk_sync (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_line (i_ps2_clk),
    .o_sync (w_clk_sync),
    .o_fall (w_clk_fall)
  );

  ps2_line_sync u_data_sync (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_line (i_ps2_data),
    .o_sync (w_data_sync),
    .o_fall (w_data_fall_unused)
  );

  assign w_tmo_run = (r_state == ST_RELEASE) || (r_state == ST_ACK) ||
                     (r_state == ST_WAIT_IDLE);
  assign w_tmo_hit = (r_tcnt == TCW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_tcnt      <= '0;
      r_shreg     <= '0;
      r_bitcnt    <= '0;
      r_nack      <= 1'b0;
      r_clk_oe    <= 1'b0;
      r_data_oe   <= 1'b0;
      r_done      <= 1'b0;
      r_ack_error <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      r_done      <= 1'b0;
      r_ack_error <= 1'b0;
      r_timeout   <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          if (i_tx_valid) begin
            r_shreg  <= ps2_frame(i_tx_data);
            r_bitcnt <= '0;
            r_cnt    <= '0;
            r_clk_oe <= 1'b1;
            r_state  <= ST_INHIBIT;
          end
        end
        ST_INHIBIT: begin
          if (r_cnt == ICW'(INHIBIT_CYCLES - 1)) begin
            r_data_oe <= 1'b1;
            r_state   <= ST_REQ;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_REQ: begin
          // start bit stays driven; the device now owns the clock
          r_clk_oe <= 1'b0;
          r_tcnt   <= '0;
          r_state  <= ST_RELEASE;
        end
        ST_RELEASE: begin
          if (w_clk_fall) begin
            r_data_oe <= ~r_shreg[0];
            r_shreg   <= {1'b0, r_shreg[PS2_FRAME_BITS-1:1]};
            r_bitcnt  <= r_bitcnt + 1'b1;
            if (r_bitcnt == 4'(PS2_FRAME_BITS - 1))
              r_state <= ST_ACK;
          end
        end
        ST_ACK: begin
          if (w_clk_fall) begin
            r_nack  <= (w_data_sync != PS2_ACK_OK);
            r_state <= ST_WAIT_IDLE;
          end
        end
        ST_WAIT_IDLE: begin
          if (w_clk_sync && w_data_sync) begin
            r_done      <= 1'b1;
            r_ack_error <= r_nack;
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase

      // Watchdog restarts on every device clock edge so a slow but live
      // device finishes its frame; a stalled bus aborts after the window.
      if (w_tmo_run) begin
        if (w_tmo_hit) begin
          r_clk_oe    <= 1'b0;
          r_data_oe   <= 1'b0;
          r_timeout   <= 1'b1;
          r_done      <= 1'b0;
          r_ack_error <= 1'b0;
          r_state     <= ST_IDLE;
        end else if (w_clk_fall && (r_state != ST_WAIT_IDLE)) begin
          r_tcnt <= '0;
        end else begin
          r_tcnt <= r_tcnt + 1'b1;
        end
      end
    end
  end

  assign o_tx_ready    = (r_state == ST_IDLE);
  assign o_busy        = (r_state != ST_IDLE);
  assign o_ps2_clk_oe  = r_clk_oe;
  assign o_ps2_data_oe = r_data_oe;
  assign o_done        = r_done;
  assign o_ack_error   = r_ack_error;
  assign o_timeout     = r_timeout;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx: a device model clocks frames in, acks or
// nacks, stalls, or gets reset mid-frame; expected wire bits are hand-coded.
module tb_ps2_host_tx;

  localparam int INH = 8;
  localparam int TMO = 400;

  logic       clk = 1'b0;
  logic       rst;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;
  logic       clk_oe, data_oe, busy, done, ack_error, timeout;
  logic       dev_clk_low, dev_data_low;
  logic       w_ps2_clk, w_ps2_data;

  assign w_ps2_clk  = ~(clk_oe | dev_clk_low);
  assign w_ps2_data = ~(data_oe | dev_data_low);

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_tx_valid    (tx_valid),
    .i_tx_data     (tx_data),
    .o_tx_ready    (tx_ready),
    .i_ps2_clk     (w_ps2_clk),
    .i_ps2_data    (w_ps2_data),
    .o_ps2_clk_oe  (clk_oe),
    .o_ps2_data_oe (data_oe),
    .o_busy        (busy),
    .o_done        (done),
    .o_ack_error   (ack_error),
    .o_timeout     (timeout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // pulse / level counters, sampled just after each active edge
  int n_done = 0, n_aerr = 0, n_to = 0, n_clkoe = 0;
  int done_cyc = 0, aerr_cyc = 0;
  always @(posedge clk) begin
    #1;
    if (done)      begin n_done++; done_cyc = cyc; end
    if (ack_error) begin n_aerr++; aerr_cyc = cyc; end
    if (timeout)   n_to++;
    if (clk_oe)    n_clkoe++;
  end

  int checks = 0, errors = 0;
  int s_done, s_aerr, s_to, s_clkoe;
  int rel_cyc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  task automatic snap();
    s_done = n_done; s_aerr = n_aerr; s_to = n_to; s_clkoe = n_clkoe;
  endtask

  task automatic start_byte(input logic [7:0] d);
    @(negedge clk); tx_valid = 1'b1; tx_data = d;
    @(negedge clk); tx_valid = 1'b0;
  endtask

  // Device model: waits for request-to-send, then clocks npulse bits (40-cycle
  // period); bits[0] is the start bit, bits[k] is read at the k-th rising edge.
  task automatic dev_frame(input int npulse, input bit do_ack, input int rel,
                           output logic [10:0] bits);
    int n = 0;
    bits = '0;
    while (!(w_ps2_clk && !w_ps2_data) && n < 300) begin @(negedge clk); n++; end
    if (n >= 300) begin chk("req_seen", 0, 1); return; end
    repeat (5) @(negedge clk);
    bits[0] = w_ps2_data;
    for (int k = 1; k <= npulse; k++) begin
      if (k == 11 && do_ack) begin dev_data_low = 1'b1; repeat (5) @(negedge clk); end
      dev_clk_low = 1'b1;
      repeat (20) @(negedge clk);
      dev_clk_low = 1'b0;
      if (k <= 10) begin
        bits[k] = w_ps2_data;
        repeat (20) @(negedge clk);
      end else begin
        if (!do_ack) rel_cyc = cyc;
        repeat (rel) @(negedge clk);
        if (do_ack) begin dev_data_low = 1'b0; rel_cyc = cyc; end
      end
    end
  endtask

  // Runs the device side of an already accepted frame and checks the result.
  task automatic run_frame(input string nm, input logic [10:0] exp_bits,
                           input bit do_ack, input int rel, input int exp_err);
    logic [10:0] bits;
    int n = 0;
    dev_frame(11, do_ack, rel, bits);
    while (n_done == s_done && n_to == s_to && n < 200) begin @(negedge clk); n++; end
    repeat (2) @(negedge clk);
    chk({nm, " bits"}, 32'(bits), 32'(exp_bits));
    chk({nm, " done_cnt"}, n_done - s_done, 1);
    chk({nm, " ack_err_cnt"}, n_aerr - s_aerr, exp_err);
    chk({nm, " timeout_cnt"}, n_to - s_to, 0);
    chk({nm, " clk_oe_cycles"}, n_clkoe - s_clkoe, INH + 1);
    chk({nm, " done_after_idle"}, 32'((done_cyc >= rel_cyc + 3) && (done_cyc <= rel_cyc + 4)), 1);
    if (exp_err != 0) chk({nm, " err_with_done"}, aerr_cyc, done_cyc);
    chk({nm, " idle_state"}, {tx_ready, busy, clk_oe, data_oe}, 4'b1000);
  endtask

  typedef struct {
    string       nm;
    logic [7:0]  d;
    bit          ack;
    int          rel;
    int          exp_err;
    logic [10:0] bits;   // {stop, parity, d7..d0, start}
  } vec_t;

  vec_t vecs[3];

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    logic [10:0] b;
    int n;
    vecs[0] = '{"ed_ack",   8'hED, 1'b1,   5, 0, 11'b1_1_11101101_0};
    vecs[1] = '{"01_nack",  8'h01, 1'b0,  20, 1, 11'b1_0_00000001_0};
    vecs[2] = '{"55_slow",  8'h55, 1'b1, 100, 0, 11'b1_1_01010101_0};

    rst = 1'b1; tx_valid = 1'b0; tx_data = '0; dev_clk_low = 1'b0; dev_data_low = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst tx_ready", tx_ready, 1);
    chk("rst busy", busy, 0);
    chk("rst oe", {clk_oe, data_oe}, 0);
    chk("rst pulses", {done, ack_error, timeout}, 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    for (int i = 0; i < 3; i++) begin
      snap();
      start_byte(vecs[i].d);
      chk({vecs[i].nm, " busy"}, busy, 1);
      run_frame(vecs[i].nm, vecs[i].bits, vecs[i].ack, vecs[i].rel, vecs[i].exp_err);
      repeat (10) @(negedge clk);
    end

    // stalled device: abort exactly TMO cycles after the clock is released
    snap();
    start_byte(8'hFF);
    n = 0;
    while (!(w_ps2_clk && !w_ps2_data) && n < 100) begin @(negedge clk); n++; end
    chk("ff release_seen", 32'(n < 100), 1);
    rel_cyc = cyc;
    n = 0;
    while (!timeout && n < 500) begin @(negedge clk); n++; end
    chk("ff timeout_latency", cyc - rel_cyc, TMO);
    @(negedge clk);
    chk("ff timeout_one_pulse", n_to - s_to, 1);
    chk("ff no_done", n_done - s_done, 0);
    chk("ff after", {tx_ready, busy, clk_oe, data_oe, timeout}, 5'b10000);
    repeat (10) @(negedge clk);

    // reset after bit 4 of a frame, then a clean 0x00 frame
    snap();
    start_byte(8'hA5);
    dev_frame(4, 1'b0, 0, b);
    chk("a5 first_bits", 32'(b[4:0]), 32'(5'b01010));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid oe_busy", {clk_oe, data_oe, busy}, 0);
    chk("rst_mid pulses", {done, ack_error, timeout}, 0);
    repeat (20) @(negedge clk);
    chk("rst_mid no_done_to", (n_done - s_done) + (n_to - s_to), 0);
    snap();
    start_byte(8'h00);
    run_frame("00_after_rst", 11'b1_1_00000000_0, 1'b1, 5, 0);
    repeat (10) @(negedge clk);

    // 0xAA held valid through a 0xF4 frame
    snap();
    @(negedge clk); tx_valid = 1'b1; tx_data = 8'hF4;
    @(negedge clk); tx_data = 8'hAA;
    chk("hold busy", busy, 1);
    dev_frame(11, 1'b1, 5, b);
    chk("f4 bits", 32'(b), 32'(11'b1_0_11110100_0));
    n = 0;
    while (!done && n < 50) begin @(negedge clk); n++; end
    chk("f4 done_seen", done, 1);
    chk("f4 ack_ok", ack_error, 0);
    chk("f4 idle_at_done", {tx_ready, clk_oe}, 2'b10);
    snap();
    @(negedge clk);
    chk("aa accepted", {tx_ready, busy, clk_oe}, 3'b011);
    tx_valid = 1'b0;
    run_frame("aa_held", 11'b1_1_10101010_0, 1'b1, 5, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
